// File: rtl/mips_multicycle_sequencer_if.sv
// mips_multicycle_sequencer_if: decoder/ALU status in, stage enables and sequencer status out.
interface mips_multicycle_sequencer_if;
   logic        start;
   logic        decoder_done;
   logic [3:0]  path_index;
   logic        exit_instruction;
   logic        alu_zero;
   logic        fetch_en;
   logic        decode_en;
   logic        alu_en;
   logic        mem_en;
   logic        wb_en;
   logic        link_wb;
   logic        pc_write;
   logic [1:0]  pc_src;
   logic        busy;
   logic        halted;
   logic        illegal;
   logic [31:0] retired;
   logic [3:0]  state;
   modport master (
      input  start, decoder_done, path_index, exit_instruction, alu_zero,
      output fetch_en, decode_en, alu_en, mem_en, wb_en, link_wb, pc_write, pc_src,
             busy, halted, illegal, retired, state
   );
   modport slave (
      output start, decoder_done, path_index, exit_instruction, alu_zero,
      input  fetch_en, decode_en, alu_en, mem_en, wb_en, link_wb, pc_write, pc_src,
             busy, halted, illegal, retired, state
   );
endinterface

// File: rtl/mips_multicycle_sequencer.sv
// mips_multicycle_sequencer: multicycle control FSM stepping one MIPS instruction through
// fetch/decode/dispatch/exec/mem/wb/pc-update with registered Moore enables.
module mips_multicycle_sequencer #(
   parameter int MULDIV_CYCLES = 8,
   parameter int MEM_LATENCY   = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   mips_multicycle_sequencer_if.master bus
);
   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_DISPATCH = 4'd3,
      S_EXEC     = 4'd4,
      S_MEM      = 4'd5,
      S_WB       = 4'd6,
      S_PCUPD    = 4'd7,
      S_HALT     = 4'd8
   } state_t;
   localparam logic [3:0] P_MF = 4'd0, P_ALU = 4'd1, P_LW = 4'd2, P_SW = 4'd3, P_BEQ = 4'd4,
                          P_J = 4'd5, P_JAL = 4'd6, P_MULDIV = 4'd7, P_JR = 4'd8, P_EXIT = 4'd9;
   state_t     st, nxt;
   logic [7:0] cnt, nxt_cnt;
   logic [3:0] path, nxt_path;
   logic       ill_set, ret_inc;
   logic [1:0] src;
   always_comb begin
      nxt      = st;
      nxt_cnt  = cnt;
      nxt_path = path;
      ill_set  = 1'b0;
      case (st)
         S_IDLE:     nxt = bus.start ? S_FETCH : S_IDLE;
         S_FETCH:    nxt = S_DECODE;
         S_DECODE:   nxt = S_DISPATCH;
         S_DISPATCH: if (bus.decoder_done) begin
            nxt_path = bus.path_index;
            if (bus.exit_instruction || bus.path_index == P_EXIT) nxt = S_HALT;
            else case (bus.path_index)
               P_MF, P_JAL:              nxt = S_WB;
               P_ALU, P_LW, P_SW, P_BEQ: begin nxt = S_EXEC; nxt_cnt = 8'd0; end
               P_MULDIV:                 begin nxt = S_EXEC; nxt_cnt = 8'(MULDIV_CYCLES - 1); end
               P_J, P_JR:                nxt = S_PCUPD;
               default:                  begin nxt = S_HALT; ill_set = 1'b1; end
            endcase
         end
         // cnt holds the remaining extra cycles of a multi-cycle EXEC or MEM phase
         S_EXEC: if (cnt != 8'd0) nxt_cnt = cnt - 8'd1;
            else if (path == P_ALU) nxt = S_WB;
            else if (path == P_LW || path == P_SW) begin nxt = S_MEM; nxt_cnt = 8'(MEM_LATENCY - 1); end
            else nxt = S_PCUPD;
         S_MEM: if (cnt != 8'd0) nxt_cnt = cnt - 8'd1;
            else nxt = (path == P_LW) ? S_WB : S_PCUPD;
         S_WB:    nxt = S_PCUPD;
         S_PCUPD: nxt = bus.start ? S_FETCH : S_IDLE;
         S_HALT:  nxt = S_HALT;
         default: nxt = S_IDLE;
      endcase
   end
   // the exit instruction counts as retired even though it never reaches PC update
   assign ret_inc = (nxt == S_PCUPD) || (st == S_DISPATCH && nxt == S_HALT && !ill_set);
   // beq samples alu_zero on the last EXEC cycle, which is the cycle PCUPD is entered from
   assign src = (nxt_path == P_BEQ) ? {1'b0, bus.alu_zero} :
                (nxt_path == P_J || nxt_path == P_JAL) ? 2'b10 :
                (nxt_path == P_JR) ? 2'b11 : 2'b00;
   assign bus.state = st;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st            <= S_IDLE;
         cnt           <= 8'd0;
         path          <= 4'd0;
         bus.fetch_en  <= 1'b0;
         bus.decode_en <= 1'b0;
         bus.alu_en    <= 1'b0;
         bus.mem_en    <= 1'b0;
         bus.wb_en     <= 1'b0;
         bus.link_wb   <= 1'b0;
         bus.pc_write  <= 1'b0;
         bus.pc_src    <= 2'b00;
         bus.busy      <= 1'b0;
         bus.halted    <= 1'b0;
         bus.illegal   <= 1'b0;
         bus.retired   <= 32'd0;
      end else begin
         st            <= nxt;
         cnt           <= nxt_cnt;
         path          <= nxt_path;
         bus.fetch_en  <= nxt == S_FETCH;
         bus.decode_en <= nxt == S_DECODE;
         bus.alu_en    <= nxt == S_EXEC;
         bus.mem_en    <= nxt == S_MEM;
         bus.wb_en     <= nxt == S_WB;
         bus.link_wb   <= nxt == S_WB && nxt_path == P_JAL;
         bus.pc_write  <= nxt == S_PCUPD;
         bus.pc_src    <= (nxt == S_PCUPD) ? src : 2'b00;
         bus.busy      <= nxt != S_IDLE && nxt != S_HALT;
         bus.halted    <= nxt == S_HALT;
         bus.illegal   <= bus.illegal | ill_set;
         bus.retired   <= bus.retired + {31'd0, ret_inc};
      end
   end
endmodule
